// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts decoded requests, drives registered operands/opcode
// into a combinational ALU, and returns the captured result with its tag.
module alu_issue_ctrl #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [1:0]       ReqClass,
  input  logic [5:0]       ReqFunct,
  input  logic [31:0]      ReqA,
  input  logic [31:0]      ReqB,
  input  logic [TAG_W-1:0] ReqTag,
  output logic [31:0]      AluA,
  output logic [31:0]      AluB,
  output logic [2:0]       AluOp,
  input  logic [31:0]      AluRes,
  input  logic             AluZero,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [31:0]      RspData,
  output logic             RspZero,
  output logic             RspIllegal,
  output logic [TAG_W-1:0] RspTag,
  output logic [CNT_W-1:0] OpCount,
  output logic [CNT_W-1:0] IllegalCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Returns {illegal, opcode}; unsupported funct maps to the undefined opcode.
  function automatic logic [3:0] decode_op(input logic [1:0] cls, input logic [5:0] funct);
    logic [3:0] res;
    case (cls)
      2'b00:   res = 4'b0_010;
      2'b01:   res = 4'b0_011;
      2'b11:   res = 4'b0_001;
      2'b10: begin
        case (funct)
          6'b100000: res = 4'b0_010;
          6'b100010: res = 4'b0_011;
          6'b100100: res = 4'b0_000;
          6'b100101: res = 4'b0_001;
          6'b100110: res = 4'b0_100;
          6'b100111: res = 4'b0_101;
          6'b101010: res = 4'b0_110;
          default:   res = 4'b1_111;
        endcase
      end
      default: res = 4'b1_111;
    endcase
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  endfunction

  state_t           state_r, state_s;
  logic             ready_r;
  logic [31:0]      alu_a_r, alu_b_r;
  logic [2:0]       alu_op_r;
  logic             illegal_r;
  logic [TAG_W-1:0] tag_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_data_r;
  logic             rsp_zero_r;
  logic             rsp_illegal_r;
  logic [TAG_W-1:0] rsp_tag_r;
  logic [CNT_W-1:0] op_cnt_r, ill_cnt_r;
  logic [3:0]       dec_s;
  logic             accept_s, hs_s;

  assign dec_s    = decode_op(ReqClass, ReqFunct);
  assign accept_s = ReqValid && ready_r;
  assign hs_s     = rsp_valid_r && RspReady;

  // Next-state logic for the issue FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = EXEC;
        else          state_s = IDLE;
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (hs_s) state_s = IDLE;
        else      state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register; ready is registered from the next state so it is low during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
    end
  end

  // Operand, opcode and request holding registers, loaded only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r   <= 32'd0;
      alu_b_r   <= 32'd0;
      alu_op_r  <= 3'b111;
      illegal_r <= 1'b0;
      tag_r     <= {TAG_W{1'b0}};
    end else if (accept_s) begin
      alu_a_r   <= ReqA;
      alu_b_r   <= ReqB;
      alu_op_r  <= dec_s[2:0];
      illegal_r <= dec_s[3];
      tag_r     <= ReqTag;
    end
  end

  // Response capture at the end of EXEC; fields hold until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= 32'd0;
      rsp_zero_r    <= 1'b0;
      rsp_illegal_r <= 1'b0;
      rsp_tag_r     <= {TAG_W{1'b0}};
    end else if (state_r == EXEC) begin
      rsp_valid_r   <= 1'b1;
      rsp_data_r    <= illegal_r ? 32'd0 : AluRes;
      rsp_zero_r    <= illegal_r ? 1'b1 : AluZero;
      rsp_illegal_r <= illegal_r;
      rsp_tag_r     <= tag_r;
    end else if (hs_s) begin
      rsp_valid_r   <= 1'b0;
    end
  end

  // Saturating statistics, updated only on a response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_r  <= {CNT_W{1'b0}};
      ill_cnt_r <= {CNT_W{1'b0}};
    end else if (hs_s) begin
      op_cnt_r <= sat_inc(op_cnt_r);
      if (rsp_illegal_r) ill_cnt_r <= sat_inc(ill_cnt_r);
    end
  end

  assign ReqReady     = ready_r;
  assign AluA         = alu_a_r;
  assign AluB         = alu_b_r;
  assign AluOp        = alu_op_r;
  assign RspValid     = rsp_valid_r;
  assign RspData      = rsp_data_r;
  assign RspZero      = rsp_zero_r;
  assign RspIllegal   = rsp_illegal_r;
  assign RspTag       = rsp_tag_r;
  assign OpCount      = op_cnt_r;
  assign IllegalCount = ill_cnt_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_class = 2'd0;
  logic [5:0]  req_funct = 6'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [3:0]  req_tag = 4'd0;
  logic        rsp_ready = 1'b0;

  logic        req_ready, alu_zero, rsp_valid, rsp_zero, rsp_illegal;
  logic [31:0] alu_a, alu_b, alu_res, rsp_data;
  logic [2:0]  alu_op;
  logic [3:0]  rsp_tag;
  logic [15:0] op_count, illegal_count;

  logic        s_req_ready, s_alu_zero, s_rsp_valid, s_rsp_zero, s_rsp_illegal;
  logic [31:0] s_alu_a, s_alu_b, s_alu_res, s_rsp_data;
  logic [2:0]  s_alu_op;
  logic [3:0]  s_rsp_tag;
  logic [1:0]  s_op_count, s_illegal_count;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  // ALU behaviour as seen by the controller: op 111 yields zero.
  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    logic [31:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b011:  r = a - b;
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a | b);
      3'b110:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero, alu_res}     = alu_f(alu_a, alu_b, alu_op);
  assign {s_alu_zero, s_alu_res} = alu_f(s_alu_a, s_alu_b, s_alu_op);

  alu_issue_ctrl #(.TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(req_valid), .ReqReady(req_ready), .ReqClass(req_class), .ReqFunct(req_funct),
    .ReqA(req_a), .ReqB(req_b), .ReqTag(req_tag),
    .AluA(alu_a), .AluB(alu_b), .AluOp(alu_op), .AluRes(alu_res), .AluZero(alu_zero),
    .RspValid(rsp_valid), .RspReady(rsp_ready), .RspData(rsp_data), .RspZero(rsp_zero),
    .RspIllegal(rsp_illegal), .RspTag(rsp_tag), .OpCount(op_count), .IllegalCount(illegal_count)
  );

  alu_issue_ctrl #(.TAG_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(req_valid), .ReqReady(s_req_ready), .ReqClass(req_class), .ReqFunct(req_funct),
    .ReqA(req_a), .ReqB(req_b), .ReqTag(req_tag),
    .AluA(s_alu_a), .AluB(s_alu_b), .AluOp(s_alu_op), .AluRes(s_alu_res), .AluZero(s_alu_zero),
    .RspValid(s_rsp_valid), .RspReady(rsp_ready), .RspData(s_rsp_data), .RspZero(s_rsp_zero),
    .RspIllegal(s_rsp_illegal), .RspTag(s_rsp_tag), .OpCount(s_op_count),
    .IllegalCount(s_illegal_count)
  );

  logic [5:0] legal_f  [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  logic [2:0] legal_op [7] = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd4, 3'd5, 3'd6};

  function automatic logic [3:0] ref_decode(input logic [1:0] cls, input logic [5:0] fn);
    logic [3:0] r;
    r = 4'b1_111;
    if (cls == 2'd0) r = 4'b0_010;
    if (cls == 2'd1) r = 4'b0_011;
    if (cls == 2'd3) r = 4'b0_001;
    if (cls == 2'd2)
      for (int k = 0; k < 7; k++)
        if (fn == legal_f[k]) r = {1'b0, legal_op[k]};
    return r;
  endfunction

  // Reference model: one outstanding transaction; the response appears one edge after acceptance.
  logic        m_ready, m_rsp_valid, m_busy, m_acc, m_hs;
  int          m_age, m_ops, m_ills;
  logic [31:0] m_a, m_b, m_rsp_data;
  logic [2:0]  m_op;
  logic        m_ill_pend, m_rsp_zero, m_rsp_ill;
  logic [3:0]  m_tag_pend, m_rsp_tag;

  task automatic model_reset();
    m_ready = 1'b0; m_rsp_valid = 1'b0; m_busy = 1'b0; m_acc = 1'b0; m_hs = 1'b0;
    m_age = 0; m_ops = 0; m_ills = 0;
    m_a = 32'd0; m_b = 32'd0; m_op = 3'b111; m_ill_pend = 1'b0; m_tag_pend = 4'd0;
    m_rsp_data = 32'd0; m_rsp_zero = 1'b0; m_rsp_ill = 1'b0; m_rsp_tag = 4'd0;
  endtask

  task automatic model_edge();
    logic [3:0] dec;
    m_acc = 1'b0;
    m_hs  = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_rsp_valid && rsp_ready) begin
        m_hs = 1'b1;
        m_ops++;
        if (m_rsp_ill) m_ills++;
        m_busy = 1'b0;
        m_rsp_valid = 1'b0;
      end else if (m_ready && req_valid) begin
        dec = ref_decode(req_class, req_funct);
        m_acc = 1'b1;
        m_a = req_a; m_b = req_b; m_op = dec[2:0]; m_ill_pend = dec[3]; m_tag_pend = req_tag;
        m_busy = 1'b1;
        m_age = 0;
      end else if (m_busy) begin
        m_age++;
        if (m_age == 1) begin
          {m_rsp_zero, m_rsp_data} = alu_f(m_a, m_b, m_op);
          if (m_ill_pend) begin
            m_rsp_zero = 1'b1;
            m_rsp_data = 32'd0;
          end
          m_rsp_ill = m_ill_pend;
          m_rsp_tag = m_tag_pend;
          m_rsp_valid = 1'b1;
        end
      end
      m_ready = !m_busy;
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] sat(input int v, input int mx);
    return 64'((v > mx) ? mx : v);
  endfunction

  // Per-cycle comparison of both instances against the reference model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ReqReady", 64'(req_ready), 64'(m_ready));
      check("RspValid", 64'(rsp_valid), 64'(m_rsp_valid));
      check("RspData", 64'(rsp_data), 64'(m_rsp_data));
      check("RspZero", 64'(rsp_zero), 64'(m_rsp_zero));
      check("RspIllegal", 64'(rsp_illegal), 64'(m_rsp_ill));
      check("RspTag", 64'(rsp_tag), 64'(m_rsp_tag));
      check("AluA", 64'(alu_a), 64'(m_a));
      check("AluB", 64'(alu_b), 64'(m_b));
      check("AluOp", 64'(alu_op), 64'(m_op));
      check("OpCount", 64'(op_count), sat(m_ops, 65535));
      check("IllegalCount", 64'(illegal_count), sat(m_ills, 65535));
      check("sat_RspValid", 64'(s_rsp_valid), 64'(m_rsp_valid));
      check("sat_RspData", 64'(s_rsp_data), 64'(m_rsp_data));
      check("sat_OpCount", 64'(s_op_count), sat(m_ops, 3));
      check("sat_IllegalCount", 64'(s_illegal_count), sat(m_ills, 3));
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Presents a request and returns at the negedge of the cycle after acceptance.
  task automatic send(input logic [1:0] cls, input logic [5:0] fn, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag);
    int n;
    n = 0;
    req_valid = 1'b1; req_class = cls; req_funct = fn; req_a = a; req_b = b; req_tag = tag;
    do begin
      step();
      n++;
    end while (!m_acc && n < 20);
    if (!m_acc) begin
      failures++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
    req_valid = 1'b0;
  endtask

  // Full transaction with RspReady high; returns at the negedge where RspValid is first high.
  task automatic run_one(input logic [1:0] cls, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
    rsp_ready = 1'b1;
    send(cls, fn, a, b, tag);
    step();
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    step();
    check("rst_ReqReady", 64'(req_ready), 64'd0);
    check("rst_AluOp", 64'(alu_op), 64'd7);
    step();
    rst_n = 1'b1;
    step();
    check("idle_ReqReady", 64'(req_ready), 64'd1);

    // R-type SUB with equal operands
    rsp_ready = 1'b1;
    send(2'b10, 6'b100010, 32'd7, 32'd7, 4'd5);
    check("sub_AluOp_N1", 64'(alu_op), 64'b011);
    check("sub_RspValid_N1", 64'(rsp_valid), 64'd0);
    step();
    check("sub_RspValid", 64'(rsp_valid), 64'd1);
    check("sub_RspData", 64'(rsp_data), 64'd0);
    check("sub_RspZero", 64'(rsp_zero), 64'd1);
    check("sub_RspTag", 64'(rsp_tag), 64'd5);
    check("sub_RspIllegal", 64'(rsp_illegal), 64'd0);
    step();
    check("sub_OpCount", 64'(op_count), 64'd1);

    run_one(2'b10, 6'b101010, 32'd3, 32'd9, 4'd1);
    check("slt_RspData", 64'(rsp_data), 64'd1);
    check("slt_RspZero", 64'(rsp_zero), 64'd0);
    step();
    run_one(2'b10, 6'b100111, 32'd0, 32'd0, 4'd2);
    check("nor_RspData", 64'(rsp_data), 64'hFFFFFFFF);
    step();

    rsp_ready = 1'b1;
    send(2'b10, 6'b000000, 32'd1, 32'd2, 4'd6);
    check("ill_AluOp", 64'(alu_op), 64'b111);
    step();
    check("ill_RspData", 64'(rsp_data), 64'd0);
    check("ill_RspZero", 64'(rsp_zero), 64'd1);
    check("ill_RspIllegal", 64'(rsp_illegal), 64'd1);
    step();
    check("ill_IllegalCount", 64'(illegal_count), 64'd1);

    run_one(2'b00, 6'd0, 32'hF0, 32'h0F, 4'd7);
    check("cls00_RspData", 64'(rsp_data), 64'hFF);
    step();
    run_one(2'b01, 6'd0, 32'hF0, 32'h0F, 4'd8);
    check("cls01_RspData", 64'(rsp_data), 64'hE1);
    step();
    run_one(2'b11, 6'd0, 32'hF0, 32'h0F, 4'd9);
    check("cls11_RspData", 64'(rsp_data), 64'hFF);
    step();

    // Back-pressure with a second request waiting
    rsp_ready = 1'b0;
    send(2'b00, 6'd0, 32'h11, 32'h22, 4'd3);
    step();
    req_valid = 1'b1; req_class = 2'b11; req_a = 32'hAAAA; req_b = 32'h5555; req_tag = 4'd10;
    for (int i = 0; i < 5; i++) begin
      check("bp_ReqReady", 64'(req_ready), 64'd0);
      check("bp_RspValid", 64'(rsp_valid), 64'd1);
      check("bp_RspData", 64'(rsp_data), 64'h33);
      check("bp_RspTag", 64'(rsp_tag), 64'd3);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_hs_ReqReady", 64'(req_ready), 64'd1);
    check("bp_hs_AluA", 64'(alu_a), 64'h11);
    check("bp_hs_RspValid", 64'(rsp_valid), 64'd0);
    step();
    check("bp_acc_AluA", 64'(alu_a), 64'hAAAA);
    check("bp_acc_AluOp", 64'(alu_op), 64'b001);
    check("bp_acc_ReqReady", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    step();
    check("bp2_RspData", 64'(rsp_data), 64'hFFFF);
    check("bp2_RspTag", 64'(rsp_tag), 64'd10);
    step();
    check("sat_OpCount_lit", 64'(s_op_count), 64'd3);
    check("full_OpCount_lit", 64'(op_count), 64'd9);

    // Reset in the middle of a stalled response
    rsp_ready = 1'b0;
    send(2'b00, 6'd0, 32'd1, 32'd2, 4'd1);
    step();
    check("mid_RspValid_pre", 64'(rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_RspValid", 64'(rsp_valid), 64'd0);
    check("mid_rst_ReqReady", 64'(req_ready), 64'd0);
    check("mid_rst_AluOp", 64'(alu_op), 64'd7);
    check("mid_rst_OpCount", 64'(op_count), 64'd0);
    check("mid_rst_satOpCount", 64'(s_op_count), 64'd0);
    step();
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    check("mid_rel_ReqReady", 64'(req_ready), 64'd0);
    step();
    check("mid_idle_ReqReady", 64'(req_ready), 64'd1);

    // Randomized traffic; a request is held until the model accepts it
    for (int i = 0; i < 600; i++) begin
      if (!req_valid || m_acc) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_class = 2'($urandom_range(0, 3));
        req_funct = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 6)];
        req_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
        req_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
        req_tag   = 4'($urandom);
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    if (m_ops >= 3) check("end_sat_OpCount", 64'(s_op_count), 64'd3);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operand/opcode interface: accepts decoded-instruction requests over a valid/ready handshake.
- Translates the main-control ALU class plus R-type funct into the 3-bit ALU opcode, then drives registered operands and opcode into the combinational ALU.
- Captures the ALU result and zero flag, and returns them with the request tag over a second valid/ready handshake.
- Sits between the decode stage and the ALU in the multi-cycle datapath.

Parameters:
- TAG_W, 4, width of the request/response tag.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- ReqValid  input  1  request present
- ReqReady  output  1  block can accept a request this cycle
- ReqClass  input  2  main-control class: 00 ADD, 01 SUB, 10 use Funct, 11 OR
- ReqFunct  input  6  R-type funct field
- ReqA  input  32  operand 1
- ReqB  input  32  operand 2
- ReqTag  input  TAG_W  opaque tag echoed in response
- AluA  output  32  operand 1 to ALU
- AluB  output  32  operand 2 to ALU
- AluOp  output  3  opcode to ALU
- AluRes  input  32  ALU result (combinational from AluA/AluB/AluOp)
- AluZero  input  1  ALU zero flag
- RspValid  output  1  response present
- RspReady  input  1  consumer accepts response
- RspData  output  32  captured result
- RspZero  output  1  captured zero flag
- RspIllegal  output  1  request had an unsupported funct
- RspTag  output  TAG_W  echoed tag
- OpCount  output  CNT_W  completed responses, saturating
- IllegalCount  output  CNT_W  completed illegal responses, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs read 0 and the FSM is in IDLE.
  - AluOp resets to 3'b111, the undefined code, so the ALU outputs 0.
  - ReqReady reads 0 during reset and 1 in IDLE afterwards.
- Opcode decode (applied at acceptance):
  - Class 00 -> 010; class 01 -> 011; class 11 -> 001.
  - Class 10 decodes Funct: 100000 -> 010 ADD, 100010 -> 011 SUB, 100100 -> 000 AND, 100101 -> 001 OR, 100110 -> 100 XOR, 100111 -> 101 NOR, 101010 -> 110 SLT.
  - Any other funct -> AluOp 111 and the illegal bit is set.
- FSM states and transitions:
  - IDLE:
    - ReqReady=1. On ReqValid&ReqReady (cycle N), latch ReqA/ReqB into AluA/AluB, the decoded opcode into AluOp, and tag/illegal into holding registers; go to EXEC.
  - EXEC (cycle N+1):
    - ReqReady=0; ALU inputs are stable.
    - At the end of the cycle, capture AluRes/AluZero into RspData/RspZero, then go to RESP. RspValid=1 from cycle N+2.
  - RESP:
    - RspValid=1; RspData, RspZero, RspIllegal and RspTag are held stable until RspValid&RspReady.
    - On handshake: increment counters, drop RspValid the next cycle and return to IDLE.
    - ReqReady is 0 in RESP; no request overlaps an outstanding response.
    - RspReady held high gives one request per 3 cycles.
- Latency: acceptance at N -> RspValid at N+2 (minimum); response may stall indefinitely.
- AluA/AluB/AluOp hold their last values after the response; they change only on acceptance.
- Illegal requests still complete normally: RspData=0, RspZero=1, RspIllegal=1.
- Counters:
  - Both increment only on a response handshake and saturate at all-ones (no wrap).
  - IllegalCount increments only when RspIllegal=1.
- ReqValid while not ready: ignored. The requester must hold its request; no internal buffering.
- RspReady asserted while RspValid=0: no effect.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no counter update, state returns to IDLE at once.

Test Plan:
- Reset: assert rst_n low mid-RESP -> RspValid=0, ReqReady=0 then 1 after release, AluOp=111, counters=0.
- R-type SUB: Class=10, Funct=100010, A=7, B=7, Tag=5, RspReady=1 -> AluOp=011 at N+1; at N+2 RspData=0, RspZero=1, RspTag=5, RspIllegal=0; OpCount=1.
- SLT and NOR:
  - Funct=101010, A=3, B=9 -> RspData=1, RspZero=0.
  - Funct=100111, A=0, B=0 -> RspData=FFFFFFFF.
- Illegal funct: Class=10, Funct=000000, A=1, B=2 -> AluOp=111, RspData=0, RspZero=1, RspIllegal=1; IllegalCount=1.
- Back-pressure: RspReady low for 5 cycles after RspValid, ReqValid held high with new operands -> response fields stable, ReqReady=0 throughout, second request accepted only in the cycle after the response handshake.
- Saturation: CNT_W=2, complete 5 responses -> OpCount=3, no wrap; class decode checked: 00 -> 010, 01 -> 011, 11 -> 001 with A=0xF0, B=0x0F giving 0xFF, 0xE1, 0xFF.
